// File: rtl/keccak_absorb_pkg.sv
// Shared types, state encoding and sizing helpers for the Keccak absorb sequencer.
// Beat remasking is an optional build feature selected by KECCAK_ABSORB_REMASK_EN.
package keccak_absorb_pkg;

    localparam int DEF_RATE   = 128;
    localparam int DEF_W      = 16;
    localparam int DEF_SHARES = 2;
    localparam int DEF_LANES  = 8;
    localparam int DEF_SLICES = 1;

    typedef logic [DEF_SHARES-1:0][DEF_RATE/DEF_W-1:0][DEF_W-1:0] Block_t;
    typedef logic [DEF_SHARES-1:0][DEF_LANES-1:0][DEF_SLICES-1:0] Beat_t;

    typedef enum logic [1:0] {IDLE, FEED, PERM, SQUEEZE} state_e;

    // Beats per block: lane groups times slice steps, slice step innermost.
    function automatic int beat_count(input int rate, input int w,
                                      input int lanes, input int slices);
        return (rate / w / lanes) * (w / slices);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keccak_absorb_seq_beat_mux.sv
// Selects one beat (lane group, slice step) out of the registered shared block.
// With KECCAK_ABSORB_REMASK_EN the beat is refreshed with RandxDI on the way out.
module keccak_beat_mux
    import keccak_absorb_pkg::*;
#(
    parameter int RATE          = DEF_RATE,
    parameter int W             = DEF_W,
    parameter int SHARES        = DEF_SHARES,
    parameter int ABSORB_LANES  = DEF_LANES,
    parameter int ABSORB_SLICES = DEF_SLICES,
    parameter int N             = beat_count(RATE, W, ABSORB_LANES, ABSORB_SLICES),
    parameter int BW            = idx_w(N)
) (
    input  logic [SHARES-1:0][RATE/W-1:0][W-1:0]                   block_i,
    input  logic [BW-1:0]                                          beat_i,
`ifdef KECCAK_ABSORB_REMASK_EN
    input  logic [SHARES-2:0][ABSORB_LANES-1:0][ABSORB_SLICES-1:0] rand_i,
`endif
    output logic [SHARES-1:0][ABSORB_LANES-1:0][ABSORB_SLICES-1:0] beat_o
);

    localparam int NS = W / ABSORB_SLICES;

    logic [SHARES-1:0][ABSORB_LANES-1:0][N-1:0][ABSORB_SLICES-1:0] opts;
    logic [SHARES-1:0][ABSORB_LANES-1:0][ABSORB_SLICES-1:0]        sel;

    // Beat index b maps to group b/NS and slice step b%NS.
    for (genvar i = 0; i < SHARES; i++) begin : g_share
        for (genvar j = 0; j < ABSORB_LANES; j++) begin : g_lane
            for (genvar b = 0; b < N; b++) begin : g_opt
                assign opts[i][j][b] =
                    block_i[i][(b / NS) * ABSORB_LANES + j][(b % NS) * ABSORB_SLICES +: ABSORB_SLICES];
            end
            assign sel[i][j] = opts[i][j][beat_i];
        end
    end

`ifdef KECCAK_ABSORB_REMASK_EN
    logic [SHARES-2:0][ABSORB_LANES-1:0][ABSORB_SLICES-1:0] acc;

    // Every random slice enters twice, so the unshared value is preserved.
    assign acc[0] = rand_i[0];
    for (genvar i = 1; i < SHARES - 1; i++) begin : g_acc
        assign acc[i] = acc[i-1] ^ rand_i[i];
    end
    for (genvar i = 0; i < SHARES - 1; i++) begin : g_mask
        assign beat_o[i] = sel[i] ^ rand_i[i];
    end
    assign beat_o[SHARES-1] = sel[SHARES-1] ^ acc[SHARES-2];
`else
    assign beat_o = sel;
`endif

endmodule

// File: rtl/keccak_absorb_seq.sv
// Serialises one shared rate block into absorb beats for keccak_top, waits out the
// permutation and requests a squeeze after a last block. Remask: KECCAK_ABSORB_REMASK_EN.
module keccak_absorb_seq
    import keccak_absorb_pkg::*;
#(
    parameter int RATE          = DEF_RATE,
    parameter int W             = DEF_W,
    parameter int SHARES        = DEF_SHARES,
    parameter int ABSORB_LANES  = DEF_LANES,
    parameter int ABSORB_SLICES = DEF_SLICES
) (
    input  logic                                          ClkxCI,
    input  logic                                          RstxRI,
    input  logic                                          BlockValidxSI,
    output logic                                          BlockReadyxSO,
    input  logic [SHARES*(RATE/W)*W-1:0]                  BlockxDI,
    input  logic                                          LastxSI,
    output logic                                          StartAbsorbxSO,
    input  logic                                          CoreReadyxSI,
    output logic [SHARES*ABSORB_LANES*ABSORB_SLICES-1:0]  AbsorbSlicesxDO,
    output logic                                          StartSqueezexSO,
    output logic [15:0]                                   BlockCountxDO
`ifdef KECCAK_ABSORB_REMASK_EN
    ,
    input  logic [(SHARES-1)*ABSORB_LANES*ABSORB_SLICES-1:0] RandxDI
`endif
);

    localparam int N  = beat_count(RATE, W, ABSORB_LANES, ABSORB_SLICES);
    localparam int BW = idx_w(N);

    state_e                              state_q, state_d;
    logic [SHARES-1:0][RATE/W-1:0][W-1:0] block_q, block_d;
    logic                                last_q, last_d;
    logic [BW-1:0]                       beat_q, beat_d;
    logic                                seen_low_q, seen_low_d;
    logic [15:0]                         count_q, count_d;
    logic                                ready_q, ready_d;
    logic                                absorb_q, absorb_d;
    logic                                squeeze_q, squeeze_d;

    logic [SHARES-1:0][ABSORB_LANES-1:0][ABSORB_SLICES-1:0] beat_data;

    always_comb begin
        state_d    = state_q;
        block_d    = block_q;
        last_d     = last_q;
        beat_d     = beat_q;
        seen_low_d = seen_low_q;
        count_d    = count_q;
        unique case (state_q)
            IDLE: if (BlockValidxSI) begin
                block_d    = BlockxDI;
                last_d     = LastxSI;
                beat_d     = '0;
                seen_low_d = 1'b0;
                state_d    = FEED;
            end
            FEED: if (CoreReadyxSI) begin
                if (beat_q == BW'(N - 1)) begin
                    beat_d  = '0;
                    state_d = PERM;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            // Permutation is done once ready has dropped and come back.
            PERM: if (!CoreReadyxSI) begin
                seen_low_d = 1'b1;
            end else if (seen_low_q) begin
                seen_low_d = 1'b0;
                count_d    = count_q + 16'd1;
                if (last_q) begin
                    state_d = SQUEEZE;
                end else begin
                    state_d = IDLE;
                    block_d = '0;
                    last_d  = 1'b0;
                end
            end
            SQUEEZE: begin
                state_d = IDLE;
                block_d = '0;
                last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        ready_d   = (state_d == IDLE);
        absorb_d  = (state_d == FEED);
        squeeze_d = (state_d == SQUEEZE);
    end

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state_q    <= IDLE;
            block_q    <= '0;
            last_q     <= 1'b0;
            beat_q     <= '0;
            seen_low_q <= 1'b0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            absorb_q   <= 1'b0;
            squeeze_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            block_q    <= block_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            seen_low_q <= seen_low_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            absorb_q   <= absorb_d;
            squeeze_q  <= squeeze_d;
        end
    end

    keccak_beat_mux #(
        .RATE          (RATE),
        .W             (W),
        .SHARES        (SHARES),
        .ABSORB_LANES  (ABSORB_LANES),
        .ABSORB_SLICES (ABSORB_SLICES),
        .N             (N),
        .BW            (BW)
    ) u_mux (
        .block_i (block_q),
        .beat_i  (beat_q),
`ifdef KECCAK_ABSORB_REMASK_EN
        .rand_i  (RandxDI),
`endif
        .beat_o  (beat_data)
    );

    // Share data is only visible while a beat is offered.
    assign AbsorbSlicesxDO = absorb_q ? beat_data : '0;
    assign BlockReadyxSO   = ready_q;
    assign StartAbsorbxSO  = absorb_q;
    assign StartSqueezexSO = squeeze_q;
    assign BlockCountxDO   = count_q;

endmodule
